// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, RAM status encoding and memory arbiter states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive data completions while an instruction fetch is waiting;
// saturates at LIMIT so the arbiter can force an instruction grant.
module starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic at_limit_c
);

    // A limit of zero still needs a one-bit register; it simply never moves.
    localparam int unsigned CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_c = (LIMIT != 0) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between icache and dcache; data has priority
// unless the instruction side has been starved for STARVE_LIMIT data grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic d_req_c;
    logic starved_c;
    logic i_done_c;
    logic d_done_c;
    logic cnt_clr_c;

    assign d_req_c = dREN | dWEN;

    // RAM-side outputs follow the owner combinationally so aborts and resets
    // take the strobes away in the same cycle.
    always_comb begin
        state_d  = state_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        i_done_c = 1'b0;
        d_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req_c && !(iREN && starved_c)) begin
                    state_d = DGRANT;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait    = 1'b0;
                    i_done_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req_c) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait    = 1'b0;
                    d_done_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign iload = iwait ? '0 : ramload;
    assign dload = dwait ? '0 : ramload;

    assign cnt_clr_c = i_done_c | ((state_q == IDLE) & ~iREN);

    starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_counter (
        .CLK       (CLK),
        .nRST      (nRST),
        .inc       (d_done_c & iREN),
        .clr       (cnt_clr_c),
        .at_limit_c(starved_c)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an ownership-level model checked every cycle,
// plus hand-computed expectations per scenario.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned LIM = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    int nvec = 0;
    int nerr = 0;

    // Model: who owns the RAM port, and how many data grants the waiting fetch has seen.
    typedef enum int {M_NONE, M_I, M_D} own_t;
    own_t  own    = M_NONE;
    int    streak = 0;
    string order  = "";

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            own    = M_NONE;
            streak = 0;
        end else begin
            case (own)
                M_NONE: begin
                    if ((dREN || dWEN) && !(iREN && LIM != 0 && streak == int'(LIM))) begin
                        own   = M_D;
                        order = {order, "D"};
                    end else if (iREN) begin
                        own   = M_I;
                        order = {order, "I"};
                    end
                    if (!iREN) streak = 0;
                end
                M_I: begin
                    if (!iREN) own = M_NONE;
                    else if (ramstate == ACCESS) begin
                        own    = M_NONE;
                        streak = 0;
                    end
                end
                M_D: begin
                    if (!(dREN || dWEN)) own = M_NONE;
                    else if (ramstate == ACCESS) begin
                        own = M_NONE;
                        if (iREN && streak < int'(LIM)) streak = streak + 1;
                    end
                end
                default: own = M_NONE;
            endcase
        end
    end

    int          n_iw = 0, n_dw = 0, n_ren = 0, n_wen = 0;
    logic [31:0] last_iload = '0, last_dload = '0, last_store = '0;
    int          b_iw, b_dw, b_ren, b_wen, b_ord;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_s(input string name, input string act, input string exp);
        nvec = nvec + 1;
        if (act != exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic        e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_ra, e_rs;
        e_ren = 1'b0; e_wen = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        e_ra  = '0;   e_rs  = '0;
        if (nRST) begin
            if (own == M_I) begin
                e_ren = iREN;
                e_ra  = iaddr;
                e_iw  = !(iREN && ramstate == ACCESS);
            end else if (own == M_D) begin
                e_wen = dWEN;
                e_ren = dREN && !dWEN;
                e_ra  = daddr;
                e_rs  = dstore;
                e_dw  = !((dREN || dWEN) && ramstate == ACCESS);
            end
        end
        check("iwait",    32'(iwait),  32'(e_iw));
        check("dwait",    32'(dwait),  32'(e_dw));
        check("ramREN",   32'(ramREN), 32'(e_ren));
        check("ramWEN",   32'(ramWEN), 32'(e_wen));
        check("ramaddr",  ramaddr,  e_ra);
        check("ramstore", ramstore, e_rs);
        check("iload",    iload, e_iw ? 32'h0 : ramload);
        check("dload",    dload, e_dw ? 32'h0 : ramload);
        if (!iwait) begin n_iw = n_iw + 1; last_iload = iload; end
        if (!dwait) begin n_dw = n_dw + 1; last_dload = dload; end
        if (ramREN) n_ren = n_ren + 1;
        if (ramWEN) begin n_wen = n_wen + 1; last_store = ramstore; end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic snap();
        b_iw = n_iw; b_dw = n_dw; b_ren = n_ren; b_wen = n_wen; b_ord = order.len();
    endtask

    function automatic string new_order();
        if (order.len() > b_ord) return order.substr(b_ord, order.len() - 1);
        return "";
    endfunction

    task automatic idle_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
        fork
            forever begin
                @(negedge CLK);
                compare_cycle();
            end
        join_none

        #2;
        check("rst_iwait",   32'(iwait),  32'h1);
        check("rst_dwait",   32'(dwait),  32'h1);
        check("rst_ramREN",  32'(ramREN), 32'h0);
        check("rst_ramaddr", ramaddr,     32'h0);
        step(2);
        nRST = 1'b1;
        step(1);

        // Instruction read, two BUSY cycles then ACCESS
        snap();
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'h8C010004;
        step(3);
        ramstate = ACCESS;
        step(1);
        idle_inputs();
        step(2);
        check("s1_iwait_pulses", 32'(n_iw - b_iw), 32'd1);
        check("s1_iload",        last_iload,       32'h8C010004);
        check("s1_ren_cycles",   32'(n_ren - b_ren), 32'd3);
        check_s("s1_order", new_order(), "I");

        // Simultaneous requests: data first, then instruction
        snap();
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h200; ramload = 32'h11112222; ramstate = ACCESS;
        step(2);
        dREN = 1'b0;
        step(2);
        idle_inputs();
        step(1);
        check_s("s2_order", new_order(), "DI");
        check("s2_dwait_pulses", 32'(n_dw - b_dw), 32'd1);
        check("s2_iwait_pulses", 32'(n_iw - b_iw), 32'd1);
        check("s2_dload",        last_dload,       32'h11112222);

        // Starvation limit 2: data, data, then instruction
        snap();
        iREN = 1'b1; dREN = 1'b1; ramstate = ACCESS;
        step(6);
        idle_inputs();
        step(2);
        check_s("s3_order", new_order(), "DDI");
        check("s3_dwait_pulses", 32'(n_dw - b_dw), 32'd2);
        check("s3_iwait_pulses", 32'(n_iw - b_iw), 32'd1);

        // Simultaneous read and write: write wins
        snap();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
        step(2);
        ramstate = ACCESS;
        step(1);
        idle_inputs();
        step(2);
        check("s4_wen_cycles",   32'(n_wen - b_wen), 32'd2);
        check("s4_ren_cycles",   32'(n_ren - b_ren), 32'd0);
        check("s4_dwait_pulses", 32'(n_dw - b_dw),   32'd1);
        check("s4_ramstore",     last_store,         32'hDEADBEEF);

        // Data read aborted while RAM is BUSY
        snap();
        dREN = 1'b1; daddr = 32'h104; ramstate = BUSY;
        step(2);
        dREN = 1'b0;
        #1;
        check("s5_abort_ren", 32'(ramREN), 32'h0);
        step(2);
        idle_inputs();
        step(1);
        check("s5_dwait_pulses", 32'(n_dw - b_dw),   32'd0);
        check("s5_ren_cycles",   32'(n_ren - b_ren), 32'd1);
        check_s("s5_order", new_order(), "D");

        // Reset pulse during an instruction grant
        snap();
        iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
        step(1);
        check("s6_granted_ren", 32'(ramREN), 32'h1);
        nRST = 1'b0;
        #1;
        check("s6_rst_ren",     32'(ramREN), 32'h0);
        check("s6_rst_iwait",   32'(iwait),  32'h1);
        check("s6_rst_ramaddr", ramaddr,     32'h0);
        step(1);
        nRST = 1'b1;
        iREN = 1'b0;
        #1;
        check("s6_idle_ren", 32'(ramREN), 32'h0);
        step(2);
        idle_inputs();
        check("s6_iwait_pulses", 32'(n_iw - b_iw), 32'd0);

        // ERROR and FREE hold the grant without completing
        snap();
        iREN = 1'b1; iaddr = 32'h44; ramstate = ERROR; ramload = 32'hCAFE0001;
        step(2);
        ramstate = FREE;
        step(1);
        ramstate = ACCESS;
        step(1);
        idle_inputs();
        step(2);
        check("s7_ren_cycles",   32'(n_ren - b_ren), 32'd3);
        check("s7_iwait_pulses", 32'(n_iw - b_iw),   32'd1);
        check("s7_iload",        last_iload,         32'hCAFE0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
